// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use/MDU stall and branch flush controller for the RV32 pipeline
module hazard_detection_unit #(
    parameter int MDU_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IF_ID_rs1,
    input  logic [4:0]  IF_ID_rs2,
    input  logic        IF_ID_useRs1,
    input  logic        IF_ID_useRs2,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_memRead,
    input  logic        ID_EX_mdu,
    input  logic        branch_taken,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        ID_EX_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_flush,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_t;

    localparam logic [7:0] WAIT_INIT = 8'(MDU_LATENCY - 2);

    state_t     state;
    logic [7:0] cnt;
    logic       load_use;
    logic       mdu_freeze;
    logic       branch_flush;

    assign load_use = ID_EX_memRead && (ID_EX_rd != 5'd0) &&
                      ((IF_ID_useRs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                       (IF_ID_useRs2 && (IF_ID_rs2 == ID_EX_rd)));

    // Hazard classification; reset masks everything so the pipeline free-runs.
    always_comb begin
        mdu_freeze   = 1'b0;
        branch_flush = 1'b0;
        if (!reset) begin
            if (state == RUN) begin
                branch_flush = branch_taken;
                mdu_freeze   = !branch_taken && ID_EX_mdu;
            end else begin
                mdu_freeze   = (cnt != 8'd0);
            end
        end
    end

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        mdu_busy     = 1'b0;
        if (branch_flush) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (mdu_freeze) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_flush = 1'b1;
            mdu_busy     = 1'b1;
        end else if (!reset && state == RUN && load_use) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= 8'd0;
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mdu_freeze) begin
                        cnt   <= WAIT_INIT;
                        state <= MDU_WAIT;
                    end
                end
                MDU_WAIT: begin
                    // cnt==0 is the release cycle: the MDU op leaves EX at this edge.
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
            if (!PC_write) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - scoreboard bench for hazard_detection_unit (latency 4 and 2)
module tb_hazard_detection_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mr, mdu, br;

    logic        pcw4, ifw4, idw4, iff4, idf4, exf4, busy4;
    logic [31:0] stall4, flush4;
    logic        pcw2, ifw2, idw2, iff2, idf2, exf2, busy2;
    logic [31:0] stall2, flush2;

    always #5 clk = ~clk;

    hazard_detection_unit #(.MDU_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_useRs1(u1), .IF_ID_useRs2(u2),
        .ID_EX_rd(rd), .ID_EX_memRead(mr), .ID_EX_mdu(mdu), .branch_taken(br),
        .PC_write(pcw4), .IF_ID_write(ifw4), .ID_EX_write(idw4),
        .IF_ID_flush(iff4), .ID_EX_flush(idf4), .EX_MEM_flush(exf4),
        .mdu_busy(busy4), .stall_cycles(stall4), .flush_count(flush4)
    );

    hazard_detection_unit #(.MDU_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_useRs1(u1), .IF_ID_useRs2(u2),
        .ID_EX_rd(rd), .ID_EX_memRead(mr), .ID_EX_mdu(mdu), .branch_taken(br),
        .PC_write(pcw2), .IF_ID_write(ifw2), .ID_EX_write(idw2),
        .IF_ID_flush(iff2), .ID_EX_flush(idf2), .EX_MEM_flush(exf2),
        .mdu_busy(busy2), .stall_cycles(stall2), .flush_count(flush2)
    );

    // {PC_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, mdu_busy}
    localparam logic [6:0] NRM = 7'b1110000;
    localparam logic [6:0] LU  = 7'b0010100;
    localparam logic [6:0] BR  = 7'b1111100;
    localparam logic [6:0] MDU = 7'b0000011;

    typedef struct {
        string       name;
        bit          sel;
        logic [6:0]  ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic step(input string name, input bit sel, input bit preload, input logic rst,
                        input logic [4:0] a1, input logic [4:0] a2, input logic e1, input logic e2,
                        input logic [4:0] d, input logic m, input logic x, input logic b,
                        input logic [6:0] ctrl, input logic [31:0] st, input logic [31:0] fl);
        exp_t e;
        @(posedge clk);
        #1;
        if (preload) begin
            force dut4.stall_cycles = 32'hFFFF_FFFF;
            #1;
            release dut4.stall_cycles;
        end
        reset = rst; rs1 = a1; rs2 = a2; u1 = e1; u2 = e2;
        rd = d; mr = m; mdu = x; br = b;
        e.name = name; e.sel = sel; e.ctrl = ctrl; e.stall = st; e.flush = fl;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [6:0]  act;
        logic [31:0] ast, afl;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    act = {pcw2, ifw2, idw2, iff2, idf2, exf2, busy2};
                    ast = stall2; afl = flush2;
                end else begin
                    act = {pcw4, ifw4, idw4, iff4, idf4, exf4, busy4};
                    ast = stall4; afl = flush4;
                end
                checks++;
                if (act !== e.ctrl) begin
                    failures++;
                    $display("FAIL %s ctrl actual=%b expected=%b", e.name, act, e.ctrl);
                end
                checks++;
                if (ast !== e.stall || afl !== e.flush) begin
                    failures++;
                    $display("FAIL %s counters actual stall=%h flush=%h expected stall=%h flush=%h",
                             e.name, ast, afl, e.stall, e.flush);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; rd = '0; mr = 0; mdu = 0; br = 0;
        repeat (2) @(posedge clk);
        //     name        sel pre rst rs1 rs2 u1 u2 rd mr mdu br  ctrl stall         flush
        step("rst",       0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 32'd0, 32'd0);
        step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 32'd0, 32'd0);
        step("lu_rs2",    0, 0, 0, 0, 5, 0, 1, 5, 1, 0, 0, LU,  32'd0, 32'd0);
        step("lu_bubble", 0, 0, 0, 0, 5, 0, 1, 5, 0, 0, 0, NRM, 32'd1, 32'd0);
        step("rd_x0",     0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, NRM, 32'd1, 32'd0);
        step("unused_rs2",0, 0, 0, 3, 7, 1, 0, 7, 1, 0, 0, NRM, 32'd1, 32'd0);
        step("lu_rs1",    0, 0, 0, 9, 0, 1, 0, 9, 1, 0, 0, LU,  32'd1, 32'd0);
        step("br_over_lu",0, 0, 0, 9, 0, 1, 0, 9, 1, 0, 1, BR,  32'd2, 32'd0);
        step("post_br",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 32'd2, 32'd1);
        step("mdu_det",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU, 32'd2, 32'd1);
        step("mdu_w1_br", 0, 0, 0, 4, 0, 1, 0, 4, 1, 1, 1, MDU, 32'd3, 32'd1);
        step("mdu_w2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU, 32'd4, 32'd1);
        step("mdu_rel",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 32'd5, 32'd1);
        step("mdu_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 32'd5, 32'd1);
        step("rm_det",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU, 32'd5, 32'd1);
        step("rm_reset",  0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 32'd6, 32'd1);
        step("rm_post",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 32'd0, 32'd0);
        step("rm_run_lu", 0, 0, 0, 2, 0, 1, 0, 2, 1, 0, 0, LU,  32'd0, 32'd0);
        step("rm_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 32'd1, 32'd0);
        step("wrap_lu",   0, 1, 0, 0, 6, 0, 1, 6, 1, 0, 0, LU,  32'hFFFF_FFFF, 32'd0);
        step("wrap_zero", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 32'd0, 32'd0);
        step("l2_det",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU, 32'd2, 32'd0);
        step("l2_rel",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 32'd3, 32'd0);
        step("l2_run_lu", 1, 0, 0, 0, 8, 0, 1, 8, 1, 0, 0, LU,  32'd3, 32'd0);
        @(posedge clk);
        #1;
        mr = 0; mdu = 0; br = 0;
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
